// File: rtl/led_sequence_monitor.sv
// rtl/led_sequence_monitor.sv - passive checker for the up/down bounce sequence on the LED bus
module led_sequence_monitor #(
   parameter int WIDTH        = 4,
   parameter int STALL_CYCLES = 8000000,
   parameter int STALL_W      = 24
) (
   input  logic             clk,
   input  logic             rst_btn,
   input  logic             clear,
   input  logic [WIDTH-1:0] led,
   output logic [2:0]       state,
   output logic             err_pulse,
   output logic             err,
   output logic [7:0]       err_count,
   output logic [7:0]       round_count
);

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_UP         = 3'd1,
      S_DOWN       = 3'd2,
      S_PAUSE_UP   = 3'd3,
      S_PAUSE_DOWN = 3'd4,
      S_LOST       = 3'd5
   } state_t;

   localparam logic [WIDTH-1:0]   LED_ZERO   = '0;
   localparam logic [WIDTH-1:0]   LED_ONE    = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0]   LED_MAX    = '1;
   localparam logic [STALL_W-1:0] STALL_MAX  = STALL_W'(STALL_CYCLES);
   localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_CYCLES - 1);

   state_t             state_q;
   state_t             state_d;
   logic [WIDTH-1:0]   led_q;
   logic [WIDTH-1:0]   step;
   logic [STALL_W-1:0] stall_cnt;
   logic [STALL_W-1:0] stall_d;
   logic               changed;
   logic               up_step;
   logic               down_step;
   logic               at_zero;
   logic               at_max;
   logic               stall_hit;
   logic               bad;
   logic               round_inc;

   assign state = state_q;

   // Classify the step between the previous sample and the current LED value.
   always_comb begin
      step      = led - led_q;
      changed   = (led != led_q);
      up_step   = changed && (step == LED_ONE);
      down_step = changed && (step == LED_MAX);
      at_zero   = (led_q == LED_ZERO);
      at_max    = (led_q == LED_MAX);
      // This sample would be the STALL_CYCLES-th unchanged one in a row.
      stall_hit = (stall_cnt >= STALL_LAST);
      if (changed) begin
         stall_d = '0;
      end else if (stall_cnt == STALL_MAX) begin
         stall_d = stall_cnt;
      end else begin
         stall_d = stall_cnt + 1'b1;
      end
   end

   // Next phase of the bounce sequence, plus error and turnaround strobes.
   always_comb begin
      state_d   = state_q;
      bad       = 1'b0;
      round_inc = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (changed) begin
               if (up_step && at_zero) begin
                  state_d = S_UP;
               end else begin
                  bad     = 1'b1;
                  state_d = S_LOST;
               end
            end
         end
         S_UP, S_PAUSE_UP: begin
            if (changed) begin
               if (up_step && !at_max) begin
                  state_d = S_UP;
               end else if (down_step && at_max) begin
                  state_d = S_DOWN;
               end else begin
                  bad     = 1'b1;
                  state_d = S_LOST;
               end
            end else if ((state_q == S_UP) && stall_hit) begin
               state_d = S_PAUSE_UP;
            end
         end
         S_DOWN, S_PAUSE_DOWN: begin
            if (changed) begin
               if (down_step && !at_zero) begin
                  state_d = S_DOWN;
               end else if (up_step && at_zero) begin
                  state_d   = S_UP;
                  round_inc = 1'b1;
               end else begin
                  bad     = 1'b1;
                  state_d = S_LOST;
               end
            end else if ((state_q == S_DOWN) && stall_hit) begin
               state_d = S_PAUSE_DOWN;
            end
         end
         S_LOST: begin
            // Resynchronise on the first legal step; stalls are not tracked here.
            if (up_step) begin
               state_d = S_UP;
            end else if (down_step) begin
               state_d = S_DOWN;
            end else if (changed) begin
               bad = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Register the sample, stall timer, phase and error/round bookkeeping; clear overrides all but the sample.
   always_ff @(posedge clk or negedge rst_btn) begin
      if (!rst_btn) begin
         led_q       <= '0;
         stall_cnt   <= '0;
         state_q     <= S_IDLE;
         err_pulse   <= 1'b0;
         err         <= 1'b0;
         err_count   <= 8'd0;
         round_count <= 8'd0;
      end else begin
         led_q <= led;
         if (clear) begin
            stall_cnt   <= '0;
            state_q     <= S_IDLE;
            err_pulse   <= 1'b0;
            err         <= 1'b0;
            err_count   <= 8'd0;
            round_count <= 8'd0;
         end else begin
            stall_cnt <= stall_d;
            state_q   <= state_d;
            err_pulse <= bad;
            if (bad) begin
               err <= 1'b1;
               if (err_count != 8'hFF) begin
                  err_count <= err_count + 8'd1;
               end
            end
            if (round_inc) begin
               round_count <= round_count + 8'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_led_sequence_monitor.sv
// tb/tb_led_sequence_monitor.sv - directed self-checking bench for led_sequence_monitor
module tb_led_sequence_monitor;

   localparam int ST_IDLE       = 0;
   localparam int ST_UP         = 1;
   localparam int ST_DOWN       = 2;
   localparam int ST_PAUSE_UP   = 3;
   localparam int ST_PAUSE_DOWN = 4;
   localparam int ST_LOST       = 5;

   logic       clk;
   logic       rst_btn;
   logic       clear;
   logic [3:0] led;
   logic [2:0] state;
   logic       err_pulse;
   logic       err;
   logic [7:0] err_count;
   logic [7:0] round_count;

   int n_checks;
   int n_errors;
   int pulses;
   bit saw_pause;

   led_sequence_monitor #(
      .WIDTH        (4),
      .STALL_CYCLES (8),
      .STALL_W      (24)
   ) dut (
      .clk         (clk),
      .rst_btn     (rst_btn),
      .clear       (clear),
      .led         (led),
      .state       (state),
      .err_pulse   (err_pulse),
      .err         (err),
      .err_count   (err_count),
      .round_count (round_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if ((state == 3'(ST_PAUSE_UP)) || (state == 3'(ST_PAUSE_DOWN))) saw_pause = 1'b1;
   endtask

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      saw_pause = 1'b0;
      rst_btn   = 1'b0;
      clear     = 1'b0;
      led       = 4'd0;
      repeat (3) tick();
      check_val("rst_state", 32'(state), ST_IDLE);
      check_val("rst_err_pulse", 32'(err_pulse), 0);
      check_val("rst_err", 32'(err), 0);
      check_val("rst_err_count", 32'(err_count), 0);
      check_val("rst_round", 32'(round_count), 0);
      rst_btn = 1'b1;

      repeat (100) tick();
      check_val("idle_hold", 32'(state), ST_IDLE);

      // Full bounce 0..15..0..1 with 4 unchanged samples between steps.
      saw_pause = 1'b0;
      for (int v = 1; v <= 15; v++) begin
         led = 4'(v);
         tick();
         if (v == 1) check_val("up_entry", 32'(state), ST_UP);
         repeat (4) tick();
      end
      check_val("up_top", 32'(state), ST_UP);
      for (int v = 14; v >= 0; v--) begin
         led = 4'(v);
         tick();
         if (v == 14) check_val("turn_down", 32'(state), ST_DOWN);
         repeat (4) tick();
      end
      check_val("down_bottom", 32'(state), ST_DOWN);
      led = 4'd1;
      tick();
      check_val("turn_up", 32'(state), ST_UP);
      check_val("round_1", 32'(round_count), 1);
      check_val("bounce_err", 32'(err), 0);
      check_val("bounce_no_pause", 32'(saw_pause), 0);

      // Pause entry on the 8th unchanged sample, exit on the next up step.
      for (int v = 2; v <= 5; v++) begin
         if (v > 2) repeat (3) tick();
         led = 4'(v);
         tick();
      end
      repeat (7) tick();
      check_val("pre_pause", 32'(state), ST_UP);
      tick();
      check_val("pause_up", 32'(state), ST_PAUSE_UP);
      led = 4'd6;
      tick();
      check_val("pause_exit", 32'(state), ST_UP);
      check_val("pause_exit_err", 32'(err), 0);

      // Jump 7 -> 9, then recover with a down step.
      led = 4'd7;
      tick();
      check_val("up_at_7", 32'(state), ST_UP);
      led = 4'd9;
      tick();
      check_val("jump_pulse", 32'(err_pulse), 1);
      check_val("jump_err", 32'(err), 1);
      check_val("jump_count", 32'(err_count), 1);
      check_val("jump_lost", 32'(state), ST_LOST);
      tick();
      check_val("pulse_one_cycle", 32'(err_pulse), 0);
      check_val("lost_hold", 32'(state), ST_LOST);
      led = 4'd8;
      tick();
      check_val("lost_to_down", 32'(state), ST_DOWN);
      check_val("lost_to_down_cnt", 32'(err_count), 1);

      for (int v = 7; v >= 0; v--) begin
         led = 4'(v);
         tick();
      end
      check_val("down_to_0", 32'(state), ST_DOWN);
      led = 4'd1;
      tick();
      check_val("turn_up_2", 32'(state), ST_UP);
      check_val("round_2", 32'(round_count), 2);

      // Change on the same edge as the stall threshold: change wins.
      repeat (7) tick();
      led = 4'd2;
      tick();
      check_val("stall_tie", 32'(state), ST_UP);

      // Wrap 15 -> 0 while counting up is illegal.
      for (int v = 3; v <= 15; v++) begin
         led = 4'(v);
         tick();
      end
      check_val("up_to_15", 32'(state), ST_UP);
      led = 4'd0;
      tick();
      check_val("wrap_up_pulse", 32'(err_pulse), 1);
      check_val("wrap_up_lost", 32'(state), ST_LOST);
      check_val("wrap_up_count", 32'(err_count), 2);
      led = 4'd15;
      tick();
      check_val("lost_down_step", 32'(state), ST_DOWN);
      check_val("lost_down_cnt", 32'(err_count), 2);

      // Wrap 0 -> 15 while counting down is illegal.
      for (int v = 14; v >= 0; v--) begin
         led = 4'(v);
         tick();
      end
      led = 4'd15;
      tick();
      check_val("wrap_dn_pulse", 32'(err_pulse), 1);
      check_val("wrap_dn_lost", 32'(state), ST_LOST);
      check_val("wrap_dn_count", 32'(err_count), 3);

      // 300 back-to-back jumps saturate the error counter.
      pulses = 0;
      for (int i = 0; i < 300; i++) begin
         led = (i % 2 == 0) ? 4'd3 : 4'd8;
         tick();
         if (err_pulse) pulses++;
      end
      check_val("jump_pulses", pulses, 300);
      check_val("err_sat", 32'(err_count), 255);
      check_val("jump_state", 32'(state), ST_LOST);

      // Clear together with a jump.
      led   = 4'd3;
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check_val("clr_state", 32'(state), ST_IDLE);
      check_val("clr_err", 32'(err), 0);
      check_val("clr_count", 32'(err_count), 0);
      check_val("clr_pulse", 32'(err_pulse), 0);
      check_val("clr_round", 32'(round_count), 0);

      // From IDLE at 3, a jump to 0 is an error; then climb and descend into DOWN.
      led = 4'd0;
      tick();
      check_val("idle_jump", 32'(state), ST_LOST);
      check_val("idle_jump_cnt", 32'(err_count), 1);
      for (int v = 1; v <= 15; v++) begin
         led = 4'(v);
         tick();
      end
      for (int v = 14; v >= 10; v--) begin
         led = 4'(v);
         tick();
      end
      check_val("pre_rst_state", 32'(state), ST_DOWN);
      check_val("pre_rst_err", 32'(err), 1);

      // Asynchronous reset between clock edges.
      @(posedge clk);
      #3;
      rst_btn = 1'b0;
      #1;
      check_val("arst_state", 32'(state), ST_IDLE);
      check_val("arst_err", 32'(err), 0);
      check_val("arst_count", 32'(err_count), 0);
      check_val("arst_pulse", 32'(err_pulse), 0);
      check_val("arst_round", 32'(round_count), 0);
      #1;
      rst_btn = 1'b1;
      led     = 4'd0;
      tick();
      check_val("post_rst_idle", 32'(state), ST_IDLE);
      led = 4'd1;
      tick();
      check_val("post_rst_up", 32'(state), ST_UP);
      check_val("post_rst_err", 32'(err), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
